// File: rtl/rx_link_pkg.sv
// Shared receive-link constants and the deframer state type.
// Used by the SPI deframer, the memory-stage correlators and the TX framer.
package rx_link_pkg;

   localparam int unsigned PIX_PER_PKT = 80;
   localparam int unsigned HDR_BITS    = 48;
   localparam int unsigned PIX_BITS    = 12;

   localparam logic [31:0] SYNC_HS  = 32'h6cf4ae21;
   localparam logic [31:0] SYNC_VS0 = 32'h93aaaade;
   localparam logic [31:0] SYNC_VS1 = 32'h935555de;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_DRAIN
   } rx_state_e;

endpackage

// File: rtl/rx_spi_deframer_if.sv
// SPI read bus from the radio plus the deframer's outputs to the memory stage.
//   SCLK/MISO/CS_n            : SPI bus (driven by the link side)
//   RxHeader                  : high while header bits are received
//   RxAdd/RxAddValid          : line address and accept pulse
//   RxData/RxValid            : pixel word and strobe
//   RxVs0/RxVs1/RxAbort       : frame-sync and abort pulses
//   PktCount/ErrCount         : link status counters
// slave  : the deframer side
// master : the link/consumer side
interface rx_spi_deframer_if;

   logic        SCLK;
   logic        MISO;
   logic        CS_n;
   logic        RxHeader;
   logic [15:0] RxAdd;
   logic        RxAddValid;
   logic [11:0] RxData;
   logic        RxValid;
   logic        RxVs0;
   logic        RxVs1;
   logic        RxAbort;
   logic [15:0] PktCount;
   logic [15:0] ErrCount;

   modport slave (
      input  SCLK, MISO, CS_n,
      output RxHeader, RxAdd, RxAddValid, RxData, RxValid,
             RxVs0, RxVs1, RxAbort, PktCount, ErrCount
   );

   modport master (
      output SCLK, MISO, CS_n,
      input  RxHeader, RxAdd, RxAddValid, RxData, RxValid,
             RxVs0, RxVs1, RxAbort, PktCount, ErrCount
   );

endinterface

// File: rtl/rx_spi_sync.sv
// Synchronises the asynchronous SPI bus into the Cclk domain and
// produces SCLK rising-edge and CS_n edge strobes.
//   Cclk        : system clock
//   sclk_i      : raw SPI clock
//   miso_i      : raw SPI data
//   cs_n_i      : raw chip select (active low)
//   sclk_rise_o : one-cycle strobe, synchronised SCLK 0->1
//   miso_s_o    : synchronised MISO, aligned with the SCLK stage used for edges
//   cs_fall_o   : one-cycle strobe, synchronised CS_n 1->0
//   cs_rise_o   : one-cycle strobe, synchronised CS_n 0->1
//   cs_s_o      : synchronised CS_n level
// The stages are deliberately not reset: a reset with CS_n held low must
// not manufacture a falling edge and restart a packet mid-stream.
module rx_spi_sync (
   input  logic Cclk,
   input  logic sclk_i,
   input  logic miso_i,
   input  logic cs_n_i,
   output logic sclk_rise_o,
   output logic miso_s_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic cs_s_o
);

   logic [2:0] sclk_q;
   logic [1:0] miso_q;
   logic [2:0] cs_q;

   always_ff @(posedge Cclk) begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      miso_q <= {miso_q[0], miso_i};
      cs_q   <= {cs_q[1:0], cs_n_i};
   end

   assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
   assign miso_s_o    = miso_q[1];
   assign cs_fall_o   = ~cs_q[1] & cs_q[2];
   assign cs_rise_o   = cs_q[1] & ~cs_q[2];
   assign cs_s_o      = cs_q[1];

endmodule

// File: rtl/rx_spi_deframer.sv
// Splits CS_n-framed SPI packets into a 48-bit header and fixed-length
// runs of 12-bit pixels for the receive memory stage; decodes sync words
// and keeps packet/error counters.
//   Cclk : system clock (SCLK period >= 8 Cclk)
//   rst  : synchronous active-high reset
//   bus  : SPI inputs and all deframer outputs (see rx_spi_deframer_if)
//
// state      | meaning
// IDLE       | waiting for CS_n falling edge
// HEADER     | shifting 48 header bits, decode one cycle after the last
// PAYLOAD    | assembling 12-bit pixels until PIX_PER_PKT delivered
// DRAIN      | ignoring bits until CS_n returns high
module rx_spi_deframer
   import rx_link_pkg::*;
(
   input  logic             Cclk,
   input  logic             rst,
   rx_spi_deframer_if.slave bus
);

   logic sclk_rise, miso_s, cs_fall, cs_rise, cs_s;

   rx_spi_sync u_sync (
      .Cclk        (Cclk),
      .sclk_i      (bus.SCLK),
      .miso_i      (bus.MISO),
      .cs_n_i      (bus.CS_n),
      .sclk_rise_o (sclk_rise),
      .miso_s_o    (miso_s),
      .cs_fall_o   (cs_fall),
      .cs_rise_o   (cs_rise),
      .cs_s_o      (cs_s)
   );

   rx_state_e   state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  pix_cnt_q, pix_cnt_d;
   logic [47:0] hdr_sr_q, hdr_sr_d;
   logic [11:0] pix_sr_q, pix_sr_d;
   logic        hdr_done_q, hdr_done_d;
   logic        pix_done_q, pix_done_d;
   logic [15:0] rx_add_q, rx_add_d;
   logic        add_vld_q, add_vld_d;
   logic [11:0] rx_data_q, rx_data_d;
   logic        rx_vld_q, rx_vld_d;
   logic        vs0_q, vs0_d;
   logic        vs1_q, vs1_d;
   logic        abort_q, abort_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic        err_inc;

   always_ff @(posedge Cclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         pix_cnt_q  <= '0;
         hdr_sr_q   <= '0;
         pix_sr_q   <= '0;
         hdr_done_q <= 1'b0;
         pix_done_q <= 1'b0;
         rx_add_q   <= '0;
         add_vld_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_vld_q   <= 1'b0;
         vs0_q      <= 1'b0;
         vs1_q      <= 1'b0;
         abort_q    <= 1'b0;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         hdr_sr_q   <= hdr_sr_d;
         pix_sr_q   <= pix_sr_d;
         hdr_done_q <= hdr_done_d;
         pix_done_q <= pix_done_d;
         rx_add_q   <= rx_add_d;
         add_vld_q  <= add_vld_d;
         rx_data_q  <= rx_data_d;
         rx_vld_q   <= rx_vld_d;
         vs0_q      <= vs0_d;
         vs1_q      <= vs1_d;
         abort_q    <= abort_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      pix_cnt_d  = pix_cnt_q;
      hdr_sr_d   = hdr_sr_q;
      pix_sr_d   = pix_sr_q;
      hdr_done_d = 1'b0;
      pix_done_d = 1'b0;
      rx_add_d   = rx_add_q;
      add_vld_d  = 1'b0;
      rx_data_d  = rx_data_q;
      rx_vld_d   = 1'b0;
      vs0_d      = 1'b0;
      vs1_d      = 1'b0;
      abort_d    = 1'b0;
      pkt_cnt_d  = pkt_cnt_q;
      err_inc    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_HEADER;
               bit_cnt_d = '0;
            end
         end
         ST_HEADER: begin
            if (hdr_done_q) begin
               bit_cnt_d = '0;
               pix_cnt_d = '0;
               if (hdr_sr_q[47:16] == SYNC_HS) begin
                  rx_add_d  = hdr_sr_q[15:0];
                  add_vld_d = 1'b1;
                  state_d   = ST_PAYLOAD;
               end else if (hdr_sr_q[47:16] == SYNC_VS0) begin
                  vs0_d   = 1'b1;
                  state_d = ST_DRAIN;
               end else if (hdr_sr_q[47:16] == SYNC_VS1) begin
                  vs1_d   = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  err_inc = 1'b1;
                  state_d = ST_DRAIN;
               end
            end else if (sclk_rise) begin
               hdr_sr_d = {hdr_sr_q[46:0], miso_s};
               if (bit_cnt_q == 6'(HDR_BITS - 1)) begin
                  hdr_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (pix_done_q) begin
               rx_data_d = pix_sr_q;
               rx_vld_d  = 1'b1;
               pix_cnt_d = pix_cnt_q + 8'd1;
               if (pix_cnt_q == 8'(PIX_PER_PKT - 1)) begin
                  pkt_cnt_d = pkt_cnt_q + 16'd1;
                  state_d   = ST_DRAIN;
               end
            end else if (sclk_rise) begin
               pix_sr_d = {pix_sr_q[10:0], miso_s};
               if (bit_cnt_q == 6'(PIX_BITS - 1)) begin
                  pix_done_d = 1'b1;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (cs_s) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // CS_n released before the packet finished: drop everything in flight.
      if ((state_q == ST_HEADER || state_q == ST_PAYLOAD) && cs_rise &&
          state_d != ST_DRAIN) begin
         state_d    = ST_IDLE;
         abort_d    = 1'b1;
         err_inc    = 1'b1;
         hdr_done_d = 1'b0;
         pix_done_d = 1'b0;
         add_vld_d  = 1'b0;
         rx_vld_d   = 1'b0;
         rx_add_d   = rx_add_q;
         rx_data_d  = rx_data_q;
      end

      err_cnt_d = err_cnt_q;
      if (err_inc && err_cnt_q != 16'hffff) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   assign bus.RxHeader   = (state_q == ST_HEADER);
   assign bus.RxAdd      = rx_add_q;
   assign bus.RxAddValid = add_vld_q;
   assign bus.RxData     = rx_data_q;
   assign bus.RxValid    = rx_vld_q;
   assign bus.RxVs0      = vs0_q;
   assign bus.RxVs1      = vs1_q;
   assign bus.RxAbort    = abort_q;
   assign bus.PktCount   = pkt_cnt_q;
   assign bus.ErrCount   = err_cnt_q;

endmodule

// File: tb/tb_rx_spi_deframer.sv
`timescale 1ns/1ps
module tb_rx_spi_deframer;
   import rx_link_pkg::*;

   logic Cclk = 1'b0;
   logic rst  = 1'b1;

   rx_spi_deframer_if bus();

   rx_spi_deframer dut (
      .Cclk (Cclk),
      .rst  (rst),
      .bus  (bus)
   );

   initial forever #5 Cclk = ~Cclk;

   typedef struct {
      string       name;
      logic [47:0] hdr;
      int          full_pix;
      int          pix_base;
      int          extra;
      int          addv;
      int          vs0;
      int          vs1;
      int          abrt;
      int          valid;
      logic [15:0] add;
      logic [15:0] pkt;
      logic [15:0] err;
   } vec_t;

   vec_t vecs[8];

   int n_cmp  = 0;
   int n_fail = 0;

   // monitor-owned
   int tot_valid = 0, tot_addv = 0, tot_vs0 = 0, tot_vs1 = 0;
   int tot_abort = 0, tot_hdr = 0, pix_bad = 0, lat_bad = 0, ovl_bad = 0;
   // driver-owned
   longint t_rise   = 0;
   int     cur_base = 0;
   int     base_snap = 0;
   int s_valid, s_addv, s_vs0, s_vs1, s_abort, s_hdr;

   function automatic bit lat_ok();
      return ((longint'($time) - t_rise) / 10) == 4;
   endfunction

   always @(negedge Cclk) begin
      if (bus.RxHeader) tot_hdr++;
      if (bus.RxValid) begin
         if (bus.RxData !== 12'(cur_base + tot_valid - base_snap)) pix_bad++;
         if (!lat_ok()) lat_bad++;
         tot_valid++;
      end
      if (bus.RxAddValid) begin
         tot_addv++;
         if (!lat_ok()) lat_bad++;
         if (bus.RxValid) ovl_bad++;
      end
      if (bus.RxVs0) begin
         tot_vs0++;
         if (!lat_ok()) lat_bad++;
      end
      if (bus.RxVs1) begin
         tot_vs1++;
         if (!lat_ok()) lat_bad++;
      end
      if (bus.RxAbort) tot_abort++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Cclk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.MISO = b;
      tick(4);
      bus.SCLK = 1'b1;
      t_rise   = longint'($time);
      tick(4);
      bus.SCLK = 1'b0;
   endtask

   task automatic send_bits(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_pixels(input int base, input int first, input int cnt);
      logic [47:0] w;
      for (int p = first; p < first + cnt; p++) begin
         w = 48'((base + p) & 32'hfff);
         send_bits(w, 12);
      end
   endtask

   task automatic snap();
      s_valid = tot_valid; s_addv = tot_addv; s_vs0 = tot_vs0;
      s_vs1 = tot_vs1; s_abort = tot_abort; s_hdr = tot_hdr;
   endtask

   task automatic end_packet();
      tick(4);
      bus.CS_n = 1'b1;
      tick(16);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_RxHeader"},   64'(bus.RxHeader),   64'd0);
      chk({pfx, "_RxAdd"},      64'(bus.RxAdd),      64'd0);
      chk({pfx, "_RxAddValid"}, 64'(bus.RxAddValid), 64'd0);
      chk({pfx, "_RxData"},     64'(bus.RxData),     64'd0);
      chk({pfx, "_RxValid"},    64'(bus.RxValid),    64'd0);
      chk({pfx, "_RxVs0"},      64'(bus.RxVs0),      64'd0);
      chk({pfx, "_RxVs1"},      64'(bus.RxVs1),      64'd0);
      chk({pfx, "_RxAbort"},    64'(bus.RxAbort),    64'd0);
      chk({pfx, "_PktCount"},   64'(bus.PktCount),   64'd0);
      chk({pfx, "_ErrCount"},   64'(bus.ErrCount),   64'd0);
   endtask

   task automatic set_vec(input int k, input string nm, input logic [47:0] hdr,
                          input int fp, input int pb, input int ex,
                          input int addv, input int v0, input int v1, input int ab,
                          input int vl, input logic [15:0] add,
                          input logic [15:0] pkt, input logic [15:0] err);
      vecs[k].name = nm;   vecs[k].hdr = hdr;   vecs[k].full_pix = fp;
      vecs[k].pix_base = pb; vecs[k].extra = ex; vecs[k].addv = addv;
      vecs[k].vs0 = v0;    vecs[k].vs1 = v1;    vecs[k].abrt = ab;
      vecs[k].valid = vl;  vecs[k].add = add;   vecs[k].pkt = pkt;
      vecs[k].err = err;
   endtask

   initial begin
      bus.SCLK = 1'b0;
      bus.MISO = 1'b0;
      bus.CS_n = 1'b1;

      //          name          header                 pix base    extra adv v0 v1 ab val  RxAdd     Pkt Err
      set_vec(0, "line0",     48'h6cf4ae21_0050, 80, 'h000,   0,  1, 0, 0, 0, 80, 16'h0050, 1, 0);
      set_vec(1, "vs0",       48'h93aaaade_0000,  0, 'h000, 200,  0, 1, 0, 0,  0, 16'h0050, 1, 0);
      set_vec(2, "vs1",       48'h935555de_0000,  0, 'h000, 200,  0, 0, 1, 0,  0, 16'h0050, 1, 0);
      set_vec(3, "abort",     48'h6cf4ae21_0a00, 30, 'h100,   5,  1, 0, 0, 1, 30, 16'h0a00, 1, 1);
      set_vec(4, "post_abrt", 48'h6cf4ae21_0050, 80, 'h200,   0,  1, 0, 0, 0, 80, 16'h0050, 2, 1);
      set_vec(5, "unknown",   48'hdeadbeef_1234,  0, 'h000, 960,  0, 0, 0, 0,  0, 16'h0050, 2, 2);
      set_vec(6, "b2b_a",     48'h6cf4ae21_0050, 80, 'h300,   0,  1, 0, 0, 0, 80, 16'h0050, 3, 2);
      set_vec(7, "b2b_b",     48'h6cf4ae21_00a0, 80, 'h400,   0,  1, 0, 0, 0, 80, 16'h00a0, 4, 2);

      tick(6);
      @(negedge Cclk);
      chk_zero("reset");
      #1;
      rst = 1'b0;
      tick(4);

      for (int k = 0; k < 8; k++) begin
         snap();
         cur_base  = vecs[k].pix_base;
         base_snap = tot_valid;
         bus.CS_n  = 1'b0;
         send_bits(vecs[k].hdr, 48);
         send_pixels(vecs[k].pix_base, 0, vecs[k].full_pix);
         for (int e = 0; e < vecs[k].extra; e++) send_bit(1'b1);
         end_packet();
         chk({vecs[k].name, "_addvalid"}, 64'(tot_addv - s_addv),   64'(vecs[k].addv));
         chk({vecs[k].name, "_vs0"},      64'(tot_vs0 - s_vs0),     64'(vecs[k].vs0));
         chk({vecs[k].name, "_vs1"},      64'(tot_vs1 - s_vs1),     64'(vecs[k].vs1));
         chk({vecs[k].name, "_abort"},    64'(tot_abort - s_abort), 64'(vecs[k].abrt));
         chk({vecs[k].name, "_valid"},    64'(tot_valid - s_valid), 64'(vecs[k].valid));
         chk({vecs[k].name, "_RxAdd"},    64'(bus.RxAdd),           64'(vecs[k].add));
         chk({vecs[k].name, "_PktCount"}, 64'(bus.PktCount),        64'(vecs[k].pkt));
         chk({vecs[k].name, "_ErrCount"}, 64'(bus.ErrCount),        64'(vecs[k].err));
         chk_rng({vecs[k].name, "_hdr_cycles"}, tot_hdr - s_hdr, 376, 386);
         chk({vecs[k].name, "_pix_data_errs"}, 64'(pix_bad), 64'd0);
         chk({vecs[k].name, "_latency_errs"},  64'(lat_bad), 64'd0);
         chk({vecs[k].name, "_overlap_errs"},  64'(ovl_bad), 64'd0);
      end

      // Reset in the middle of the payload, after pixel 10 has been delivered.
      snap();
      cur_base  = 'h500;
      base_snap = tot_valid;
      bus.CS_n  = 1'b0;
      send_bits(48'h6cf4ae21_0123, 48);
      send_pixels('h500, 0, 10);
      tick(1);
      chk("midrst_valid_before", 64'(tot_valid - s_valid), 64'd10);
      chk("midrst_add_before",   64'(bus.RxAdd), 64'h0123);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge Cclk);
      chk_zero("midrst");
      #1;
      snap();
      send_pixels('h500, 10, PIX_PER_PKT - 10);
      end_packet();
      chk("midrst_ignored_valid", 64'(tot_valid - s_valid), 64'd0);
      chk("midrst_ignored_addv",  64'(tot_addv - s_addv),   64'd0);
      chk("midrst_ignored_hdr",   64'(tot_hdr - s_hdr),     64'd0);
      chk("midrst_ignored_pkt",   64'(bus.PktCount),        64'd0);
      chk("midrst_ignored_err",   64'(bus.ErrCount),        64'd0);

      snap();
      cur_base  = 'h600;
      base_snap = tot_valid;
      bus.CS_n  = 1'b0;
      send_bits(48'h6cf4ae21_0077, 48);
      send_pixels('h600, 0, PIX_PER_PKT);
      end_packet();
      chk("postrst_valid",    64'(tot_valid - s_valid), 64'd80);
      chk("postrst_addv",     64'(tot_addv - s_addv),   64'd1);
      chk("postrst_RxAdd",    64'(bus.RxAdd),           64'h0077);
      chk("postrst_PktCount", 64'(bus.PktCount),        64'd1);
      chk("postrst_ErrCount", 64'(bus.ErrCount),        64'd0);
      chk("postrst_pix_errs", 64'(pix_bad),             64'd0);
      chk("postrst_lat_errs", 64'(lat_bad),             64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
